// File: rtl/pipememstage.sv
// Memory stage: EXE/MEM and MEM/WB pipeline registers plus a request/acknowledge
// data-memory sequencer. Optional misalignment check under PIPEMEM_ALIGN_CHK_EN.
module pipememstage (
  input  logic        clock,
  input  logic        reset,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        dack,
  input  logic [31:0] drdata,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic        mstall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
`ifdef PIPEMEM_ALIGN_CHK_EN
  ,
  output logic        malign
`endif
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic        busy;
  logic        mem_op_e;
  logic        start_e;
  logic        bad_align_e;

  logic        mwreg_q, mm2reg_q, mwmem_q;
  logic [31:0] malu_q, mb_q;
  logic [4:0]  mrn_q;
  logic        malign_q;

  logic        wwreg_q, wm2reg_q;
  logic [31:0] wmo_q, walu_q;
  logic [4:0]  wrn_q;

  assign mem_op_e = em2reg | ewmem;
`ifdef PIPEMEM_ALIGN_CHK_EN
  assign bad_align_e = mem_op_e & (ealu[1:0] != 2'b00);
`else
  assign bad_align_e = 1'b0;
`endif
  // A misaligned op still enters EXE/MEM but never raises a request.
  assign start_e = mem_op_e & ~bad_align_e;

  assign busy = (state_q == ACCESS);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mstall  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start_e ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (!dack) begin
          mstall  = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = start_e ? ACCESS : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= '0;
      mb_q     <= '0;
      mrn_q    <= '0;
      malign_q <= 1'b0;
    end else if (!mstall) begin
      mwreg_q  <= ewreg;
      mm2reg_q <= em2reg;
      mwmem_q  <= ewmem;
      malu_q   <= ealu;
      mb_q     <= eb;
      mrn_q    <= ern;
      malign_q <= bad_align_e;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wmo_q    <= '0;
      walu_q   <= '0;
      wrn_q    <= '0;
    end else if (!mstall) begin
      wwreg_q  <= mwreg_q & ~malign_q;
      wm2reg_q <= mm2reg_q;
      wmo_q    <= (mm2reg_q & busy) ? drdata : '0;
      walu_q   <= malu_q;
      wrn_q    <= mrn_q;
    end else begin
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
    end
  end

  assign mwreg  = mwreg_q;
  assign mm2reg = mm2reg_q;
  assign mwmem  = mwmem_q;
  assign malu   = malu_q;
  assign mrn    = mrn_q;

  assign dreq   = busy;
  assign dwe    = busy & mwmem_q;
  assign daddr  = malu_q;
  assign dwdata = mb_q;

  assign wwreg  = wwreg_q;
  assign wm2reg = wm2reg_q;
  assign wmo    = wmo_q;
  assign walu   = walu_q;
  assign wrn    = wrn_q;

`ifdef PIPEMEM_ALIGN_CHK_EN
  assign malign = malign_q;
`else
  logic unused_align;
  assign unused_align = malign_q;
`endif

endmodule

// File: tb/tb_pipememstage.sv
// Bench for pipememstage: directed scenarios plus a randomized run against a
// transaction-level model with a bench-side word memory.
module tb_pipememstage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ewreg, em2reg, ewmem;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        dack;
  logic [31:0] drdata;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu;
  logic [4:0]  mrn;
  logic        dreq, dwe;
  logic [31:0] daddr, dwdata;
  logic        mstall;
  logic        wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;
`ifdef PIPEMEM_ALIGN_CHK_EN
  logic        malign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  pipememstage dut (
    .clock(clock), .reset(reset),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealu(ealu), .eb(eb), .ern(ern),
    .dack(dack), .drdata(drdata),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mrn(mrn),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .mstall(mstall),
    .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn)
`ifdef PIPEMEM_ALIGN_CHK_EN
    , .malign(malign)
`endif
  );

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
  } instr_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ex(input logic w, input logic l, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    ewreg = w; em2reg = l; ewmem = s; ealu = a; eb = d; ern = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ex(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b0, $urandom, $urandom, 5'($urandom_range(0,31)));
    dack = 1'($urandom_range(0,1)); drdata = $urandom;
    step(); step();
    n_checks++; if ({mwreg,mm2reg,mwmem,malu,mrn,dreq,dwe,daddr,dwdata,mstall,wwreg,wm2reg,wmo,walu,wrn} !== '0)
      $display("FAIL reset_outputs got nonzero dreq=%0b mstall=%0b malu=%h wmo=%h exp all 0", dreq, mstall, malu, wmo);
    else n_pass++;
`ifdef PIPEMEM_ALIGN_CHK_EN
    n_checks++; if (malign !== 1'b0) $display("FAIL reset_malign got %0b exp 0", malign); else n_pass++;
`endif
    reset = 1'b0; dack = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
    #1;
    n_checks++; if (dreq !== 1'b0) $display("FAIL alu_dreq0 got %0b exp 0", dreq); else n_pass++;
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    n_checks++; if (mwreg !== 1'b1) $display("FAIL alu_mwreg got %0b exp 1", mwreg); else n_pass++;
    n_checks++; if (dreq !== 1'b0) $display("FAIL alu_dreq1 got %0b exp 0", dreq); else n_pass++;
    step();
    n_checks++; if (wwreg !== 1'b1) $display("FAIL alu_wwreg got %0b exp 1", wwreg); else n_pass++;
    n_checks++; if (walu !== 32'h1234) $display("FAIL alu_walu got %h exp 00001234", walu); else n_pass++;
    n_checks++; if (wrn !== 5'd5) $display("FAIL alu_wrn got %0d exp 5", wrn); else n_pass++;
    n_checks++; if (dreq !== 1'b0) $display("FAIL alu_dreq2 got %0b exp 0", dreq); else n_pass++;
  endtask

  task automatic test_load_zero_wait();
    dack = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7);
    #1;
    n_checks++; if (mstall !== 1'b0) $display("FAIL ld_idle_stall got %0b exp 0", mstall); else n_pass++;
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drdata = 32'hCAFEF00D;
    #1;
    n_checks++; if (dreq !== 1'b1) $display("FAIL ld_dreq got %0b exp 1", dreq); else n_pass++;
    n_checks++; if (dwe !== 1'b0) $display("FAIL ld_dwe got %0b exp 0", dwe); else n_pass++;
    n_checks++; if (daddr !== 32'h100) $display("FAIL ld_daddr got %h exp 00000100", daddr); else n_pass++;
    n_checks++; if (mstall !== 1'b0) $display("FAIL ld_stall got %0b exp 0", mstall); else n_pass++;
    step();
    drdata = $urandom;
    #1;
    n_checks++; if (wmo !== 32'hCAFEF00D) $display("FAIL ld_wmo got %h exp cafef00d", wmo); else n_pass++;
    n_checks++; if (wm2reg !== 1'b1) $display("FAIL ld_wm2reg got %0b exp 1", wm2reg); else n_pass++;
    n_checks++; if (wrn !== 5'd7) $display("FAIL ld_wrn got %0d exp 7", wrn); else n_pass++;
    n_checks++; if (dreq !== 1'b0) $display("FAIL ld_dreq_end got %0b exp 0", dreq); else n_pass++;
    dack = 1'b0;
  endtask

  task automatic test_store_wait();
    dack = 1'b0;
    set_ex(1'b0, 1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 5'd0);
    step();
    set_ex(1'b1, 1'b0, 1'b0, 32'h777, 32'h0, 5'd9);
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (mstall !== 1'b1) $display("FAIL st_stall[%0d] got %0b exp 1", i, mstall); else n_pass++;
      n_checks++; if ({dreq,dwe} !== 2'b11) $display("FAIL st_req_we[%0d] got %b exp 11", i, {dreq,dwe}); else n_pass++;
      n_checks++; if (daddr !== 32'h200) $display("FAIL st_daddr[%0d] got %h exp 00000200", i, daddr); else n_pass++;
      n_checks++; if (dwdata !== 32'hA5A5A5A5) $display("FAIL st_dwdata[%0d] got %h exp a5a5a5a5", i, dwdata); else n_pass++;
      step();
      n_checks++; if ({wwreg,wm2reg} !== 2'b00) $display("FAIL st_bubble[%0d] got %b exp 00", i, {wwreg,wm2reg}); else n_pass++;
      n_checks++; if ({mwmem,malu} !== {1'b1,32'h200}) $display("FAIL st_hold[%0d] got %b/%h exp 1/00000200", i, mwmem, malu); else n_pass++;
    end
    dack = 1'b1;
    #1;
    n_checks++; if (mstall !== 1'b0) $display("FAIL st_ack_stall got %0b exp 0", mstall); else n_pass++;
    step();
    n_checks++; if ({mwreg,malu} !== {1'b1,32'h777}) $display("FAIL st_next_cap got %b/%h exp 1/00000777", mwreg, malu); else n_pass++;
    n_checks++; if ({wwreg,walu} !== {1'b0,32'h200}) $display("FAIL st_retire got %b/%h exp 0/00000200", wwreg, walu); else n_pass++;
    dack = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    n_checks++; if (dreq !== 1'b0) $display("FAIL st_alu_dreq got %0b exp 0", dreq); else n_pass++;
    step();
    n_checks++; if ({wwreg,walu,wrn} !== {1'b1,32'h777,5'd9}) $display("FAIL st_alu_wb got %b/%h/%0d exp 1/00000777/9", wwreg, walu, wrn); else n_pass++;
  endtask

  task automatic test_back_to_back();
    dack = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4);
    step();
    set_ex(1'b0, 1'b0, 1'b1, 32'h304, 32'h11223344, 5'd0);
    drdata = 32'hDEADBEEF;
    #1;
    n_checks++; if ({dreq,dwe,mstall} !== 3'b100) $display("FAIL b2b_ld got %b exp 100", {dreq,dwe,mstall}); else n_pass++;
    n_checks++; if (daddr !== 32'h300) $display("FAIL b2b_ld_addr got %h exp 00000300", daddr); else n_pass++;
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drdata = $urandom;
    #1;
    n_checks++; if ({wwreg,wmo,wrn} !== {1'b1,32'hDEADBEEF,5'd4}) $display("FAIL b2b_ld_wb got %b/%h/%0d exp 1/deadbeef/4", wwreg, wmo, wrn); else n_pass++;
    n_checks++; if ({dreq,dwe,mstall} !== 3'b110) $display("FAIL b2b_st got %b exp 110", {dreq,dwe,mstall}); else n_pass++;
    n_checks++; if ({daddr,dwdata} !== {32'h304,32'h11223344}) $display("FAIL b2b_st_bus got %h/%h exp 00000304/11223344", daddr, dwdata); else n_pass++;
    step();
    n_checks++; if ({dreq,wwreg} !== 2'b00) $display("FAIL b2b_end got %b exp 00", {dreq,wwreg}); else n_pass++;
    dack = 1'b0;
  endtask

  task automatic test_reset_during_access();
    dack = 1'b0;
    set_ex(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd3);
    step();
    #1;
    n_checks++; if (mstall !== 1'b1) $display("FAIL rst_acc_wait got %0b exp 1", mstall); else n_pass++;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dack = 1'b1; drdata = $urandom;
    #1;
    n_checks++; if ({dreq,mstall,wwreg,mm2reg} !== 4'b0000) $display("FAIL rst_acc_clear got %b exp 0000", {dreq,mstall,wwreg,mm2reg}); else n_pass++;
    step();
    n_checks++; if ({dreq,wwreg,wm2reg} !== 3'b000) $display("FAIL rst_acc_nowb got %b exp 000", {dreq,wwreg,wm2reg}); else n_pass++;
    dack = 1'b0;
  endtask

`ifdef PIPEMEM_ALIGN_CHK_EN
  task automatic test_align();
    dack = 1'b0;
    set_ex(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd6);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    n_checks++; if ({malign,dreq,mstall} !== 3'b100) $display("FAIL align_flag got %b exp 100", {malign,dreq,mstall}); else n_pass++;
    step();
    n_checks++; if ({malign,wwreg,dreq} !== 3'b000) $display("FAIL align_wb got %b exp 000", {malign,wwreg,dreq}); else n_pass++;
  endtask
`endif

  // Model: one instruction sits in MEM with a pending flag; the bench owns the memory.
  task automatic test_random();
    instr_t      cur, m_ins;
    logic        m_pend, need_new, stall, e_wwreg, e_wm2reg;
    logic [31:0] e_walu, e_wmo, ld_val;
    logic [4:0]  e_wrn;
    logic [31:0] mem [16];
    int unsigned op;
    for (int unsigned i = 0; i < 16; i++) mem[i] = 32'h5A000000 | i;
    reset = 1'b1; set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    reset = 1'b0;
    m_ins = '0; m_pend = 1'b0; need_new = 1'b1; cur = '0;
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      if (need_new) begin
        cur = '0;
        cur.rn = 5'($urandom_range(0, 31));
        op = $urandom_range(0, 2);
        if (op == 0) begin
          cur.wreg = 1'($urandom_range(0, 1)); cur.alu = $urandom; cur.b = $urandom;
        end else if (op == 1) begin
          cur.wreg = 1'b1; cur.m2reg = 1'b1; cur.alu = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end else begin
          cur.wmem = 1'b1; cur.alu = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; cur.b = $urandom;
        end
        need_new = 1'b0;
      end
      set_ex(cur.wreg, cur.m2reg, cur.wmem, cur.alu, cur.b, cur.rn);
      dack = ($urandom_range(0, 3) != 0);
      ld_val = mem[m_ins.alu[5:2]];
      drdata = (m_pend && dack && m_ins.m2reg) ? ld_val : $urandom;
      #1;
      stall = m_pend & ~dack;
      n_checks++; if ({dreq,mstall} !== {m_pend,stall}) $display("FAIL rnd_req[%0d] got %b exp %b", cyc, {dreq,mstall}, {m_pend,stall}); else n_pass++;
      if (m_pend) begin
        n_checks++; if ({dwe,daddr} !== {m_ins.wmem,m_ins.alu}) $display("FAIL rnd_bus[%0d] got %b/%h exp %b/%h", cyc, dwe, daddr, m_ins.wmem, m_ins.alu); else n_pass++;
        if (m_ins.wmem) begin
          n_checks++; if (dwdata !== m_ins.b) $display("FAIL rnd_wdata[%0d] got %h exp %h", cyc, dwdata, m_ins.b); else n_pass++;
        end
      end
      if (!stall) begin
        e_wwreg = m_ins.wreg; e_wm2reg = m_ins.m2reg; e_walu = m_ins.alu; e_wrn = m_ins.rn;
        e_wmo = m_ins.m2reg ? ld_val : 32'h0;
        if (m_pend && m_ins.wmem) mem[m_ins.alu[5:2]] = m_ins.b;
        m_ins = cur; m_pend = cur.m2reg | cur.wmem; need_new = 1'b1;
      end else begin
        e_wwreg = 1'b0; e_wm2reg = 1'b0;
      end
      step();
      n_checks++; if ({wwreg,wm2reg} !== {e_wwreg,e_wm2reg}) $display("FAIL rnd_wctl[%0d] got %b exp %b", cyc, {wwreg,wm2reg}, {e_wwreg,e_wm2reg}); else n_pass++;
      n_checks++; if ({walu,wrn,wmo} !== {e_walu,e_wrn,e_wmo}) $display("FAIL rnd_wdat[%0d] got %h/%0d/%h exp %h/%0d/%h", cyc, walu, wrn, wmo, e_walu, e_wrn, e_wmo); else n_pass++;
      n_checks++; if ({mwreg,mm2reg,mwmem,malu,mrn} !== {m_ins.wreg,m_ins.m2reg,m_ins.wmem,m_ins.alu,m_ins.rn})
        $display("FAIL rnd_mreg[%0d] got %b%b%b/%h/%0d exp %b%b%b/%h/%0d", cyc, mwreg, mm2reg, mwmem, malu, mrn, m_ins.wreg, m_ins.m2reg, m_ins.wmem, m_ins.alu, m_ins.rn);
      else n_pass++;
    end
    dack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dack = 1'b0; drdata = '0;
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_back_to_back();
    test_reset_during_access();
`ifdef PIPEMEM_ALIGN_CHK_EN
    test_align();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
